// File: rtl/cfg_scan_driver.sv
// Configuration scan driver: turns WRITE/READ/NOP commands into 39-bit MSB-first
// scan frames for a tile, captures the bits the tile shifts back, then holds.
module cfg_scan_driver #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned FRAME_W     = 39
) (
  input  logic               cfg_clk,
  input  logic               cfg_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cmd_addr,
  input  logic [31:0]        cmd_data,
  input  logic               cmd_lut_we,
  output logic               cfg_scan_en,
  output logic               cfg_scan_in,
  output logic               cfg_lut_we,
  input  logic               cfg_scan_out,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_data,
  output logic               busy
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned HOLD_W = 4;
  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_READ  = 2'b01;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [FRAME_W-2:0]   sr_q, sr_d;
  logic                 lut_pend_q, lut_pend_d;
  logic [FRAME_W-1:0]   frame_new;
  logic [FRAME_W-1:0]   rsp_d;
  logic                 scan_en_d, scan_in_d, lut_we_d, rsp_valid_d;

  // Frame layout: data[38:7], CSB[6], OEB[5] (always 1), WEB[4], addr[3:0]
  always_comb begin
    frame_new = {32'd0, 1'b1, 1'b1, 1'b1, 4'd0};
    case (cmd_op)
      OP_WRITE: frame_new = {cmd_data, 1'b0, 1'b1, 1'b0, cmd_addr};
      OP_READ:  frame_new = {32'd0,    1'b1, 1'b1, 1'b0, cmd_addr};
      default:  frame_new = {32'd0,    1'b1, 1'b1, 1'b1, 4'd0};
    endcase
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    sr_d        = sr_q;
    lut_pend_d  = lut_pend_q;
    rsp_d       = rsp_data;
    scan_en_d   = 1'b0;
    scan_in_d   = 1'b0;
    lut_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d     = SHIFT;
          shift_cnt_d = '0;
          sr_d        = frame_new[FRAME_W-2:0];
          lut_pend_d  = cmd_lut_we;
          scan_en_d   = 1'b1;
          scan_in_d   = frame_new[FRAME_W-1];
        end
      end
      SHIFT: begin
        // The tile shifts on this edge, so its output bit is captured now
        rsp_d = {rsp_data[FRAME_W-2:0], cfg_scan_out};
        sr_d  = {sr_q[FRAME_W-3:0], 1'b0};
        if (shift_cnt_q == CNT_W'(FRAME_W - 1)) begin
          state_d     = HOLD;
          shift_cnt_d = '0;
          hold_cnt_d  = '0;
          lut_we_d    = lut_pend_q;
          rsp_valid_d = (HOLD_CYCLES == 1);
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
          scan_en_d   = 1'b1;
          scan_in_d   = sr_q[FRAME_W-2];
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
          rsp_valid_d = (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 2));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cfg_clk or posedge cfg_rst) begin
    if (cfg_rst) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      hold_cnt_q  <= '0;
      sr_q        <= '0;
      lut_pend_q  <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      cfg_scan_en <= 1'b0;
      cfg_scan_in <= 1'b0;
      cfg_lut_we  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      sr_q        <= sr_d;
      lut_pend_q  <= lut_pend_d;
      cmd_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      cfg_scan_en <= scan_en_d;
      cfg_scan_in <= scan_in_d;
      cfg_lut_we  <= lut_we_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_d;
    end
  end

endmodule

// File: tb/tb_cfg_scan_driver.sv
// Directed bench for cfg_scan_driver against a behavioural 39-bit tile scan chain,
// plus a HOLD_CYCLES=1 instance for the short-hold latency.
module tb_cfg_scan_driver;

  localparam logic [38:0] FR_W3  = {32'hDEAD_BEEF, 3'b010, 4'd3};
  localparam logic [38:0] FR_W1  = {32'h1234_5678, 3'b010, 4'd1};
  localparam logic [38:0] FR_R1  = {32'h0000_0000, 3'b110, 4'd1};
  localparam logic [38:0] FR_NOP = {32'h0000_0000, 3'b111, 4'd0};
  localparam logic [38:0] FR_B5  = {32'hA5A5_0001, 3'b010, 4'd5};

  logic        cfg_clk = 1'b0;
  logic        cfg_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid1 = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_addr = 4'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_lut_we = 1'b0;
  logic        cmd_ready, cfg_scan_en, cfg_scan_in, cfg_lut_we, cfg_scan_out, rsp_valid, busy;
  logic [38:0] rsp_data;
  logic        cmd_ready1, cfg_scan_en1, cfg_scan_in1, cfg_lut_we1, rsp_valid1, busy1;
  logic        cfg_scan_out1 = 1'b0;
  logic [38:0] rsp_data1;

  int errors = 0;
  int checks = 0;

  always #5 cfg_clk = ~cfg_clk;

  cfg_scan_driver #(.HOLD_CYCLES(2), .FRAME_W(39)) dut (
    .cfg_clk(cfg_clk), .cfg_rst(cfg_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_lut_we(cmd_lut_we),
    .cfg_scan_en(cfg_scan_en), .cfg_scan_in(cfg_scan_in), .cfg_lut_we(cfg_lut_we),
    .cfg_scan_out(cfg_scan_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  cfg_scan_driver #(.HOLD_CYCLES(1), .FRAME_W(39)) dut1 (
    .cfg_clk(cfg_clk), .cfg_rst(cfg_rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_lut_we(cmd_lut_we),
    .cfg_scan_en(cfg_scan_en1), .cfg_scan_in(cfg_scan_in1), .cfg_lut_we(cfg_lut_we1),
    .cfg_scan_out(cfg_scan_out1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1)
  );

  // Tile: 39-bit scan chain, applies a write frame when the scan enable drops
  logic [38:0] tile_sr = '0;
  logic [31:0] tile_mem [16];
  logic        en_d = 1'b0;
  assign cfg_scan_out = tile_sr[38];
  always @(posedge cfg_clk) begin
    en_d <= cfg_scan_en;
    if (cfg_scan_en) tile_sr <= {tile_sr[37:0], cfg_scan_in};
    if (en_d && !cfg_scan_en && !tile_sr[6] && !tile_sr[4]) tile_mem[tile_sr[3:0]] <= tile_sr[38:7];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command on the HOLD_CYCLES=2 driver; returns to the negedge of the following IDLE cycle
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data,
                        input logic lut, output logic [38:0] stream, output int n_lut,
                        output int lut_at, output logic [38:0] rsp);
    int n_en, lat, guard;
    logic busy_first;
    stream = '0; n_en = 0; n_lut = 0; lut_at = -1; lat = -1; rsp = '0; guard = 0;
    busy_first = 1'b0;
    @(negedge cfg_clk);
    while (!cmd_ready && guard < 100) begin @(negedge cfg_clk); guard++; end
    check("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_lut_we = lut; cmd_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge cfg_clk);
      if (c == 1) begin
        cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~addr; cmd_data = ~data; cmd_lut_we = ~lut;
        busy_first = busy;
      end
      if (cfg_scan_en) begin stream = {stream[37:0], cfg_scan_in}; n_en++; end
      if (cfg_lut_we) begin n_lut++; lut_at = c; end
      if (rsp_valid) begin lat = c; rsp = rsp_data; break; end
    end
    check("busy_in_shift", 64'(busy_first), 64'd1);
    check("scan_en_cycles", 64'(n_en), 64'd39);
    check("rsp_latency", 64'(lat), 64'd41);
    @(negedge cfg_clk);
    check("rsp_data_held", 64'(rsp_data), 64'(rsp));
    check("idle_after_rsp", 64'({cmd_ready, busy, rsp_valid}), 64'b100);
  endtask

  logic [38:0] st, rs, s0;
  int          nl, lt, ne, la, guard, hs_n, last_hs, pulses, ens;
  int          hs_cyc [3] = '{0, 0, 0};
  logic [2:0]  snap;
  logic [31:0] bb_data [3] = '{32'hA5A5_0001, 32'h0000_FFFF, 32'h8000_0001};

  initial begin
    // Reset state
    repeat (3) @(negedge cfg_clk);
    check("reset_outputs", 64'({cmd_ready, cfg_scan_en, cfg_scan_in, cfg_lut_we, rsp_valid, busy}), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    cfg_rst = 1'b0;
    #1 check("ready_before_first_edge", 64'(cmd_ready), 64'd0);
    @(negedge cfg_clk);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);
    check("ready1_after_reset", 64'(cmd_ready1), 64'd1);

    // WRITE addr 3 DEADBEEF
    do_cmd(2'b00, 4'd3, 32'hDEAD_BEEF, 1'b0, st, nl, lt, rs);
    check("w3_stream", 64'(st), 64'(FR_W3));
    check("w3_no_lut", 64'(nl), 64'd0);
    check("w3_rsp", 64'(rs), 64'd0);

    // WRITE then READ addr 1
    do_cmd(2'b00, 4'd1, 32'h1234_5678, 1'b0, st, nl, lt, rs);
    check("w1_stream", 64'(st), 64'(FR_W1));
    check("w1_rsp", 64'(rs), 64'(FR_W3));
    do_cmd(2'b01, 4'd1, 32'hFFFF_FFFF, 1'b0, st, nl, lt, rs);
    check("r1_stream", 64'(st), 64'(FR_R1));
    check("r1_rsp", 64'(rs), 64'(FR_W1));
    check("tile_mem1", 64'(tile_mem[1]), 64'h1234_5678);
    check("tile_mem3", 64'(tile_mem[3]), 64'hDEAD_BEEF);

    // NOP with LUT write, then reserved opcode
    do_cmd(2'b10, 4'd9, 32'h5555_AAAA, 1'b1, st, nl, lt, rs);
    check("nop_stream", 64'(st), 64'(FR_NOP));
    check("nop_lut_count", 64'(nl), 64'd1);
    check("nop_lut_cycle", 64'(lt), 64'd40);
    check("nop_rsp", 64'(rs), 64'(FR_R1));
    do_cmd(2'b11, 4'd7, 32'h7777_7777, 1'b0, st, nl, lt, rs);
    check("rsv_stream", 64'(st), 64'(FR_NOP));
    check("rsv_rsp", 64'(rs), 64'(FR_NOP));

    // Back-to-back with cmd_valid held high; cmd_data disturbed mid-SHIFT
    cmd_op = 2'b00; cmd_addr = 4'd5; cmd_data = bb_data[0]; cmd_lut_we = 1'b0; cmd_valid = 1'b1;
    hs_n = 0; last_hs = -100; s0 = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cmd_ready) begin hs_cyc[hs_n] = cyc; hs_n++; last_hs = cyc; end
      else if (cyc == last_hs + 20) cmd_data = 32'h0BAD_F00D;
      else if (cyc == last_hs + 30 && hs_n < 3) begin
        cmd_addr = 4'(5 + hs_n); cmd_data = bb_data[hs_n];
      end
      if (hs_n == 3) break;
      @(negedge cfg_clk);
      if (hs_n == 1 && cfg_scan_en) s0 = {s0[37:0], cfg_scan_in};
    end
    @(negedge cfg_clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 100) begin @(negedge cfg_clk); guard++; end
    check("b2b_last_rsp", 64'(rsp_valid), 64'd1);
    @(negedge cfg_clk);
    check("b2b_handshakes", 64'(hs_n), 64'd3);
    check("b2b_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd42);
    check("b2b_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd42);
    check("b2b_stream0", 64'(s0), 64'(FR_B5));
    check("b2b_mem5", 64'(tile_mem[5]), 64'hA5A5_0001);
    check("b2b_mem6", 64'(tile_mem[6]), 64'h0000_FFFF);
    check("b2b_mem7", 64'(tile_mem[7]), 64'h8000_0001);

    // Reset during SHIFT k=20
    @(negedge cfg_clk);
    check("ready_before_abort", 64'(cmd_ready), 64'd1);
    cmd_op = 2'b00; cmd_addr = 4'd9; cmd_data = 32'hFFFF_FFFF; cmd_valid = 1'b1;
    @(negedge cfg_clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge cfg_clk);
    check("k20_scan", 64'({cfg_scan_en, cfg_scan_in}), 64'b11);
    cfg_rst = 1'b1;
    #1;
    check("abort_outputs", 64'({cmd_ready, cfg_scan_en, cfg_scan_in, cfg_lut_we, rsp_valid, busy}), 64'd0);
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    repeat (2) @(negedge cfg_clk);
    cfg_rst = 1'b0;
    pulses = 0; ens = 0;
    repeat (50) begin
      @(negedge cfg_clk);
      if (rsp_valid) pulses++;
      if (cfg_scan_en) ens++;
    end
    check("abort_no_rsp", 64'(pulses), 64'd0);
    check("abort_no_scan", 64'(ens), 64'd0);
    do_cmd(2'b10, 4'd0, 32'd0, 1'b1, st, nl, lt, rs);
    check("post_abort_stream", 64'(st), 64'(FR_NOP));
    check("post_abort_lut", 64'(nl), 64'd1);

    // HOLD_CYCLES=1 instance
    @(negedge cfg_clk);
    check("ready1_idle", 64'(cmd_ready1), 64'd1);
    cmd_op = 2'b00; cmd_addr = 4'd2; cmd_data = 32'h0F0F_0F0F; cmd_lut_we = 1'b1; cmd_valid1 = 1'b1;
    ne = 0; la = -1; lt = -1; snap = 3'b000;
    for (int c = 1; c <= 60; c++) begin
      @(negedge cfg_clk);
      if (c == 1) begin cmd_valid1 = 1'b0; cmd_lut_we = 1'b0; end
      if (cfg_scan_en1) ne++;
      if (cfg_lut_we1) lt = c;
      if (rsp_valid1) begin la = c; snap = {cfg_scan_en1, busy1, cfg_lut_we1}; break; end
    end
    check("h1_latency", 64'(la), 64'd40);
    check("h1_scan_cycles", 64'(ne), 64'd39);
    check("h1_lut_cycle", 64'(lt), 64'd40);
    check("h1_hold_state", 64'(snap), 64'b011);
    @(negedge cfg_clk);
    check("h1_idle_after", 64'({cmd_ready1, busy1, cfg_lut_we1, rsp_valid1}), 64'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
